sme_host_driver: RTL and testbench

- Host-side driver for the string matching engine (SME).
- Accepts string and pattern bytes from an upstream byte-stream handshake and buffers them.
- Replays them to the SME on chardata/isstring/ispattern with the SME's required contiguous framing.
- Waits for the SME's one-cycle valid pulse, then holds the result on a downstream result handshake. It is the producer/consumer at the other end of the SME interface.

---
 rtl/sme_pkg.sv | 25 ++
 rtl/sme_char_buf.sv | 66 ++++++
 rtl/sme_host_driver.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_sme_host_driver.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// Shared definitions for the SME host driver: FSM state encoding, the SME
// special-character codes and the default buffer geometry.
package sme_pkg;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_SEND_S = 3'd1,
        ST_SEND_P = 3'd2,
        ST_WAIT   = 3'd3,
        ST_REPORT = 3'd4
    } state_e;

    // Characters with special meaning to the SME pattern matcher.
    localparam logic [7:0] CH_HEAD  = 8'h5E;  // '^' anchor to string start
    localparam logic [7:0] CH_TAIL  = 8'h24;  // '$' anchor to string end
    localparam logic [7:0] CH_ANY   = 8'h2E;  // '.' matches any character
    localparam logic [7:0] CH_SPACE = 8'h20;  // word separator

    localparam int MAX_STR_DEF = 32;
    localparam int MAX_PAT_DEF = 8;
    localparam int TIMEOUT_DEF = 64;
    localparam int TO_W_DEF    = 7;
    localparam int IDX_W       = 5;   // width of the SME match_index

endpackage

// File: rtl/sme_char_buf.sv
// Byte buffer with write pointer, saturating length and sticky overflow.
// A write with restart_i set lands at address 0 and begins a new sequence.
module sme_char_buf #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic          restart_i,
    input  logic [7:0]    wr_data_i,
    input  logic          clr_len_i,
    input  logic          clr_ovf_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o,
    output logic [LW-1:0] len_o,
    output logic          ovf_next_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] base;
    logic          full;
    logic          ovf_q, ovf_d;

    // Address the incoming byte would occupy; at DEPTH it is dropped.
    assign base = restart_i ? '0 : len_q;
    assign full = (base == LW'(DEPTH));

    // Next length and overflow flag.
    always_comb begin
        len_d = len_q;
        ovf_d = ovf_q;
        if (clr_len_i) len_d = '0;
        if (clr_ovf_i) ovf_d = 1'b0;
        if (wr_en_i) begin
            if (restart_i) ovf_d = 1'b0;
            if (full) ovf_d = 1'b1;
            else      len_d = base + LW'(1);
        end
    end

    // Length and overflow state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            len_q <= len_d;
            ovf_q <= ovf_d;
        end
    end

    // Byte storage.
    // NOTE: the data array has no reset; only bytes below len_q are ever read,
    // so clearing it would only cost a reset net on every storage flop.
    always_ff @(posedge clk) begin
        if (wr_en_i && !full) mem_q[base[AW-1:0]] <= wr_data_i;
    end

    assign rd_data_o  = mem_q[rd_addr_i];
    assign len_o      = len_q;
    assign ovf_next_o = ovf_d;

endmodule

// File: rtl/sme_host_driver.sv
// Host-side driver for the string matching engine: buffers string and pattern
// bytes from an upstream stream, replays them to the SME with contiguous
// framing, waits for the result pulse and presents it on a result handshake.
module sme_host_driver
    import sme_pkg::*;
#(
    parameter int MAX_STR = MAX_STR_DEF,
    parameter int MAX_PAT = MAX_PAT_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TO_W    = TO_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_kind,
    input  logic [7:0]       in_char,
    input  logic             in_last,
    output logic [7:0]       chardata,
    output logic             isstring,
    output logic             ispattern,
    input  logic             valid,
    input  logic             match,
    input  logic [IDX_W-1:0] match_index,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_match,
    output logic [IDX_W-1:0] res_index,
    output logic             res_timeout,
    output logic             res_ovf,
    output logic             res_err
);

    localparam int SLW = $clog2(MAX_STR + 1);
    localparam int PLW = $clog2(MAX_PAT + 1);
    localparam int SAW = $clog2(MAX_STR);
    localparam int PAW = $clog2(MAX_PAT);

    state_e           state_q, state_d;
    logic [SLW-1:0]   idx_q, idx_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             str_loaded_q, str_loaded_d;
    logic             str_dirty_q, str_dirty_d;
    logic             str_fresh_q, str_fresh_d;
    logic             pat_fresh_q, pat_fresh_d;

    logic             in_ready_q, in_ready_d;
    logic [7:0]       chardata_q, chardata_d;
    logic             isstring_q, isstring_d;
    logic             ispattern_q, ispattern_d;
    logic             res_valid_q, res_valid_d;
    logic             res_match_q, res_match_d;
    logic [IDX_W-1:0] res_index_q, res_index_d;
    logic             res_timeout_q, res_timeout_d;
    logic             res_ovf_q, res_ovf_d;
    logic             res_err_q, res_err_d;

    logic             beat, str_wr, pat_wr, rep_done, ovf_any;
    logic [SAW-1:0]   s_rd_addr;
    logic [PAW-1:0]   p_rd_addr;
    logic [7:0]       s_rd_data, p_rd_data, p_first;
    logic [SLW-1:0]   str_len;
    logic [PLW-1:0]   pat_len;
    logic             s_ovf_next, p_ovf_next;

    assign beat     = in_valid & in_ready_q;
    assign str_wr   = beat & ~in_kind;
    assign pat_wr   = beat & in_kind;
    assign rep_done = (state_q == ST_REPORT) & res_ready;
    assign ovf_any  = s_ovf_next | p_ovf_next;

    // Each buffer is read from address 0 until its own replay phase.
    assign s_rd_addr = (state_q == ST_SEND_S) ? idx_q[SAW-1:0] : '0;
    assign p_rd_addr = (state_q == ST_SEND_P) ? idx_q[PAW-1:0] : '0;

    // A one-byte pattern is still being written when its replay is set up,
    // so its first byte comes straight from the input.
    assign p_first = (pat_fresh_q || pat_len == '0) ? in_char : p_rd_data;

    sme_char_buf #(.DEPTH(MAX_STR)) u_str_buf (
        .clk        (clk),
        .rst_n      (reset),
        .wr_en_i    (str_wr),
        .restart_i  (str_fresh_q),
        .wr_data_i  (in_char),
        .clr_len_i  (1'b0),
        .clr_ovf_i  (rep_done),
        .rd_addr_i  (s_rd_addr),
        .rd_data_o  (s_rd_data),
        .len_o      (str_len),
        .ovf_next_o (s_ovf_next)
    );

    sme_char_buf #(.DEPTH(MAX_PAT)) u_pat_buf (
        .clk        (clk),
        .rst_n      (reset),
        .wr_en_i    (pat_wr),
        .restart_i  (pat_fresh_q),
        .wr_data_i  (in_char),
        .clr_len_i  (rep_done),
        .clr_ovf_i  (rep_done),
        .rd_addr_i  (p_rd_addr),
        .rd_data_o  (p_rd_data),
        .len_o      (pat_len),
        .ovf_next_o (p_ovf_next)
    );

    // Next-state and next-output logic for the load/send/wait/report sequence.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        idx_d         = idx_q;
        to_cnt_d      = to_cnt_q;
        str_loaded_d  = str_loaded_q;
        str_dirty_d   = str_dirty_q;
        str_fresh_d   = str_fresh_q;
        pat_fresh_d   = pat_fresh_q;
        in_ready_d    = 1'b0;
        chardata_d    = '0;
        isstring_d    = 1'b0;
        ispattern_d   = 1'b0;
        res_valid_d   = res_valid_q;
        res_match_d   = res_match_q;
        res_index_d   = res_index_q;
        res_timeout_d = res_timeout_q;
        res_ovf_d     = res_ovf_q;
        res_err_d     = res_err_q;

        case (state_q)
            ST_LOAD: begin
                in_ready_d = 1'b1;
                if (str_wr) begin
                    str_dirty_d = 1'b1;
                    str_fresh_d = in_last;
                    pat_fresh_d = 1'b1;
                    if (in_last) str_loaded_d = 1'b1;
                end
                if (pat_wr) begin
                    pat_fresh_d = in_last;
                    str_fresh_d = 1'b1;
                    if (in_last) begin
                        in_ready_d = 1'b0;
                        if (!str_loaded_q) begin
                            state_d       = ST_REPORT;
                            res_valid_d   = 1'b1;
                            res_err_d     = 1'b1;
                            res_match_d   = 1'b0;
                            res_index_d   = '0;
                            res_timeout_d = 1'b0;
                            res_ovf_d     = ovf_any;
                        end else if (str_dirty_q) begin
                            state_d    = ST_SEND_S;
                            isstring_d = 1'b1;
                            chardata_d = s_rd_data;
                            idx_d      = SLW'(1);
                        end else begin
                            state_d     = ST_SEND_P;
                            ispattern_d = 1'b1;
                            chardata_d  = p_first;
                            idx_d       = SLW'(1);
                        end
                    end
                end
            end

            ST_SEND_S: begin
                if (idx_q < str_len) begin
                    isstring_d = 1'b1;
                    chardata_d = s_rd_data;
                    idx_d      = idx_q + SLW'(1);
                end else begin
                    state_d     = ST_SEND_P;
                    str_dirty_d = 1'b0;
                    ispattern_d = 1'b1;
                    chardata_d  = p_rd_data;
                    idx_d       = SLW'(1);
                end
            end

            ST_SEND_P: begin
                if (idx_q < SLW'(pat_len)) begin
                    ispattern_d = 1'b1;
                    chardata_d  = p_rd_data;
                    idx_d       = idx_q + SLW'(1);
                end else begin
                    state_d  = ST_WAIT;
                    to_cnt_d = '0;
                end
            end

            ST_WAIT: begin
                if (valid) begin
                    state_d       = ST_REPORT;
                    res_valid_d   = 1'b1;
                    res_match_d   = match;
                    res_index_d   = match_index;
                    res_timeout_d = 1'b0;
                    res_ovf_d     = ovf_any;
                    res_err_d     = 1'b0;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d       = ST_REPORT;
                    res_valid_d   = 1'b1;
                    res_match_d   = 1'b0;
                    res_index_d   = '0;
                    res_timeout_d = 1'b1;
                    res_ovf_d     = ovf_any;
                    res_err_d     = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            ST_REPORT: begin
                if (res_ready) begin
                    state_d       = ST_LOAD;
                    in_ready_d    = 1'b1;
                    res_valid_d   = 1'b0;
                    res_match_d   = 1'b0;
                    res_index_d   = '0;
                    res_timeout_d = 1'b0;
                    res_ovf_d     = 1'b0;
                    res_err_d     = 1'b0;
                end
            end

            default: state_d = ST_LOAD;
        endcase
    end

    // State and registered outputs; reset also discards the buffered string.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_LOAD;
            idx_q         <= '0;
            to_cnt_q      <= '0;
            str_loaded_q  <= 1'b0;
            str_dirty_q   <= 1'b0;
            str_fresh_q   <= 1'b1;
            pat_fresh_q   <= 1'b1;
            in_ready_q    <= 1'b0;
            chardata_q    <= '0;
            isstring_q    <= 1'b0;
            ispattern_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            res_match_q   <= 1'b0;
            res_index_q   <= '0;
            res_timeout_q <= 1'b0;
            res_ovf_q     <= 1'b0;
            res_err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q       <= state_d;
            idx_q         <= idx_d;
            to_cnt_q      <= to_cnt_d;
            str_loaded_q  <= str_loaded_d;
            str_dirty_q   <= str_dirty_d;
            str_fresh_q   <= str_fresh_d;
            pat_fresh_q   <= pat_fresh_d;
            in_ready_q    <= in_ready_d;
            chardata_q    <= chardata_d;
            isstring_q    <= isstring_d;
            ispattern_q   <= ispattern_d;
            res_valid_q   <= res_valid_d;
            res_match_q   <= res_match_d;
            res_index_q   <= res_index_d;
            res_timeout_q <= res_timeout_d;
            res_ovf_q     <= res_ovf_d;
            res_err_q     <= res_err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign chardata    = chardata_q;
    assign isstring    = isstring_q;
    assign ispattern   = ispattern_q;
    assign res_valid   = res_valid_q;
    assign res_match   = res_match_q;
    assign res_index   = res_index_q;
    assign res_timeout = res_timeout_q;
    assign res_ovf     = res_ovf_q;
    assign res_err     = res_err_q;

endmodule

// File: tb/tb_sme_host_driver.sv
// Directed bench for sme_host_driver: a table of jobs (string, pattern, SME
// reply, expected framing and result) plus hand-written reset/stray-pulse cases.
`timescale 1ns/1ps
module tb_sme_host_driver;
    import sme_pkg::*;

    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_kind = 1'b0;
    logic [7:0]       in_char = '0;
    logic             in_last = 1'b0;
    logic [7:0]       chardata;
    logic             isstring;
    logic             ispattern;
    logic             valid = 1'b0;
    logic             match = 1'b0;
    logic [IDX_W-1:0] match_index = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic             res_match;
    logic [IDX_W-1:0] res_index;
    logic             res_timeout;
    logic             res_ovf;
    logic             res_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [95:0] str;   int s_n;     // string bytes, first byte leftmost
        logic [95:0] pat;   int p_n;
        bit          reply; int dly;     // SME pulses valid dly cycles into WAIT
        logic        r_match; logic [4:0] r_idx;
        int          exp_s; int exp_p;   // expected strobe cycle counts
        logic        e_match; logic [4:0] e_idx;
        logic        e_to; logic e_ovf; logic e_err;
        int          hold;               // cycles res_ready stays low
    } job_t;

    job_t jobs [7];
    job_t err_job;

    sme_host_driver #(.MAX_STR(32), .MAX_PAT(8), .TIMEOUT(TIMEOUT), .TO_W(7)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_kind     (in_kind),
        .in_char     (in_char),
        .in_last     (in_last),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .valid       (valid),
        .match       (match),
        .match_index (match_index),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_match   (res_match),
        .res_index   (res_index),
        .res_timeout (res_timeout),
        .res_ovf     (res_ovf),
        .res_err     (res_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [95:0] v, input int n, input int i);
        return v[(n - 1 - i) * 8 +: 8];
    endfunction

    // Present one beat and hold it until the driver accepts it.
    task automatic send_beat(input logic kind, input logic [7:0] ch, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_kind  = kind;
        in_char  = ch;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_job(input job_t j, input string tag);
        int   k = 0, s_n = 0, p_n = 0, first_s = -1, first_p = -1, ws = -1, rise = -1;
        int   exp_rise;
        logic prev_p = 1'b0;
        for (int i = 0; i < j.s_n; i++) send_beat(1'b0, byte_at(j.str, j.s_n, i), i == j.s_n - 1);
        for (int i = 0; i < j.p_n; i++) send_beat(1'b1, byte_at(j.pat, j.p_n, i), i == j.p_n - 1);
        // Cycle 0 is the cycle right after the last pattern beat.
        while (k < 300) begin
            valid = 1'b0;
            if (res_valid === 1'b1) begin
                rise = k;
                break;
            end
            if (isstring === 1'b1) begin
                if (first_s < 0) first_s = k;
                if (s_n < j.s_n) check($sformatf("%s_sbyte%0d", tag, s_n), {24'd0, chardata}, {24'd0, byte_at(j.str, j.s_n, s_n)});
                s_n++;
            end
            if (ispattern === 1'b1) begin
                if (first_p < 0) first_p = k;
                if (p_n < j.p_n) check($sformatf("%s_pbyte%0d", tag, p_n), {24'd0, chardata}, {24'd0, byte_at(j.pat, j.p_n, p_n)});
                p_n++;
            end
            if (prev_p && ispattern !== 1'b1 && ws < 0) ws = k;
            prev_p = (ispattern === 1'b1);
            if (j.reply && ws >= 0 && k == ws + j.dly) begin
                valid       = 1'b1;
                match       = j.r_match;
                match_index = j.r_idx;
            end
            @(posedge clk); #1;
            k++;
        end
        valid = 1'b0;
        check({tag, "_s_count"}, s_n, j.exp_s);
        check({tag, "_p_count"}, p_n, j.exp_p);
        if (j.exp_s > 0) check({tag, "_first_s"}, first_s, 0);
        if (j.exp_p > 0) check({tag, "_first_p"}, first_p, j.exp_s);
        if (!j.e_err)    check({tag, "_wait_entry"}, ws, j.exp_s + j.exp_p);
        exp_rise = j.e_err ? 0 : (j.reply ? ws + j.dly + 1 : ws + TIMEOUT);
        check({tag, "_res_latency"}, rise, exp_rise);
        check({tag, "_res_match"},   {31'd0, res_match},   {31'd0, j.e_match});
        check({tag, "_res_index"},   {27'd0, res_index},   {27'd0, j.e_idx});
        check({tag, "_res_timeout"}, {31'd0, res_timeout}, {31'd0, j.e_to});
        check({tag, "_res_ovf"},     {31'd0, res_ovf},     {31'd0, j.e_ovf});
        check({tag, "_res_err"},     {31'd0, res_err},     {31'd0, j.e_err});
        for (int h = 0; h < j.hold; h++) begin
            check($sformatf("%s_hold%0d", tag, h),
                  {21'd0, res_valid, res_match, res_index, res_timeout, res_ovf, res_err, in_ready},
                  {21'd0, 1'b1, j.e_match, j.e_idx, j.e_to, j.e_ovf, j.e_err, 1'b0});
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, "_post_hs_res_valid"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_post_hs_in_ready"},  {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        //            str        s_n pat           p_n rep dly m     idx    es ep em    eidx    to    ovf   err  hold
        jobs[0] = '{"abc",        3, "b",           1, 1,  2, 1'b1, 5'd1,  3, 1, 1'b1, 5'd1,  1'b0, 1'b0, 1'b0, 0};
        jobs[1] = '{96'h0,        0, "c",           1, 1,  2, 1'b1, 5'd2,  0, 1, 1'b1, 5'd2,  1'b0, 1'b0, 1'b0, 0};
        jobs[2] = '{"hello",      5, "ll",          2, 1,  5, 1'b1, 5'd2,  5, 2, 1'b1, 5'd2,  1'b0, 1'b0, 1'b0, 5};
        jobs[3] = '{96'h0,        0, "0123456789", 10, 1,  1, 1'b0, 5'd0,  0, 8, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 0};
        jobs[4] = '{96'h0,        0, "lo",          2, 0,  0, 1'b1, 5'd7,  0, 2, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 0};
        jobs[5] = '{"ab",         2, "b",           1, 1, 63, 1'b1, 5'd1,  2, 1, 1'b1, 5'd1,  1'b0, 1'b0, 1'b0, 0};
        jobs[6] = '{96'h0,        0, "ba",          2, 1,  1, 1'b0, 5'd31, 0, 2, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0, 0};
        err_job = '{96'h0,        0, "q",           1, 0,  0, 1'b0, 5'd0,  0, 0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {12'd0, in_ready, isstring, ispattern, chardata, res_valid, res_match, res_index, res_timeout, res_ovf, res_err},
              32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_job(jobs[i], $sformatf("job%0d", i));

        // A valid pulse while loading must not produce a result.
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        check("stray_valid_res_valid", {31'd0, res_valid}, 32'd0);
        check("stray_valid_in_ready",  {31'd0, in_ready},  32'd1);

        // Reset in the middle of string replay drops the strobe at once.
        send_beat(1'b0, 8'h77, 1'b0);
        send_beat(1'b0, 8'h78, 1'b0);
        send_beat(1'b0, 8'h79, 1'b0);
        send_beat(1'b0, 8'h7A, 1'b1);
        send_beat(1'b1, 8'h77, 1'b1);
        check("rst_pre_isstring", {31'd0, isstring}, 32'd1);
        check("rst_pre_chardata", {24'd0, chardata}, 32'h77);
        #2 reset = 1'b0;
        #1;
        check("rst_async_isstring", {31'd0, isstring}, 32'd0);
        check("rst_async_chardata", {24'd0, chardata}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // The string was discarded, so a pattern-only job is an error.
        run_job(err_job, "err");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
